main_memory_responder: RTL and testbench
========================================

# main_memory_responder

Main-memory model and responder at the far end of the L2 controller's memory channel. It accepts one read or write request at a time over the valid/ready request channel and holds a backing store of `2^ADDR_W` lines. Reads return one response beat after a fixed latency; writes update the store and complete with no response beat. Used in system benches as the memory below L2 and as the memory-side endpoint for protocol checking.

## Interface
- `ADDR_W`, default 6: line address width (`ADDR_BITS - OFFSET_BITS`).
- `DATA_W`, default 1: line data width (`CACHELINE_BITS`).
- `RD_LATENCY`, default 4: cycles from read acceptance to the response beat. Legal range 1..255.
- `WR_BUSY`, default 2: cycles `mem_req_ready` stays low after a write is accepted. Legal range 0..255.
- `clk`, input, 1: the single clock for the block.
- `reset`, input, 1: synchronous reset, active-high.
- `mem_req_valid`, input, 1: request present.
- `mem_req_rw`, input, 1: 0 = read, 1 = write.
- `mem_req_addr`, input, ADDR_W: line address.
- `mem_req_data`, input, DATA_W: write data; ignored on reads.
- `mem_req_ready`, output, 1: the responder can accept a request.
- `mem_resp_valid`, output, 1: one-cycle read response strobe.
- `mem_resp_data`, output, DATA_W: read data; meaningful only while `mem_resp_valid` is high.
- `rd_count`, output, 16: accepted reads, saturating. Present only with `MEM_STATS_EN`.
- `wr_count`, output, 16: accepted writes, saturating. Present only with `MEM_STATS_EN`.

## Operation
- **Storage.** `mem[2^ADDR_W]` of `DATA_W` bits. Every line is cleared to 0 in any cycle where `reset` is high.
- **Acceptance.** A request is accepted on a rising edge where `mem_req_valid && mem_req_ready`. Only one request is outstanding at a time.
- **FSM states.** IDLE, RD_WAIT, RESP, WR_BUSY.
- **`mem_req_ready`.** Equals `(state == IDLE)`. It is a function of state only and never depends on `mem_req_valid`.
- **IDLE, read accepted.**
  - Latch `mem[addr]` into `data_q`.
  - Load `cnt = RD_LATENCY - 1`.
  - Go to RESP if `cnt == 0`; otherwise go to RD_WAIT.
- **RD_WAIT.** Decrement `cnt` each cycle. Go to RESP in the cycle `cnt` reaches 0.
- **RESP.**
  - `mem_resp_valid = 1` and `mem_resp_data = data_q` for exactly one cycle.
  - Then return to IDLE.
  - There is no response backpressure. The consumer must take the beat.
- **IDLE, write accepted.**
  - `mem[addr] <= mem_req_data` on the acceptance edge.
  - Load `cnt = WR_BUSY - 1`.
  - If `WR_BUSY == 0`, stay in IDLE (back-to-back writes every cycle). Otherwise go to WR_BUSY, which decrements `cnt` and returns to IDLE when `cnt == 0`.
- **Read data is a snapshot.** Data is captured at acceptance. Because only one request is outstanding, no later write can change it.
- **`mem_resp_data` outside RESP.** It holds the last `data_q`. Its value after reset is 0.
- **Request fields while not ready.** `mem_req_addr`, `mem_req_rw` and `mem_req_data` are ignored whenever `mem_req_ready` is low, including if they change while valid is held.

## Timing
- **Reset values.** `mem_req_ready = 1`, `mem_resp_valid = 0`, `mem_resp_data = 0`, `rd_count = wr_count = 0`, state = IDLE.
- **Read.** Accepted at edge T. `mem_resp_valid` is high during cycle T+RD_LATENCY only. `mem_req_ready` is low from T+1 through T+RD_LATENCY and high again at T+RD_LATENCY+1.
- **Back-to-back reads.** The minimum spacing between accepted reads is RD_LATENCY+1 cycles.
- **Write.** Accepted at edge T. Data is visible to a read accepted at T+WR_BUSY+1 or later. `mem_req_ready` is low for cycles T+1 .. T+WR_BUSY.
- **Reset mid-operation.** A pending read is dropped and no response strobe is produced. The write-busy period is aborted. The next cycle is IDLE with ready high.
- **Reset with valid high.** No request is accepted in a cycle where `reset` is high.
- **Address wrap.** None. Every address value maps to exactly one line.

## Configuration
- **`MEM_STATS_EN` defined:**
  - `rd_count` and `wr_count` ports exist.
  - Each increments by 1 on the edge its request type is accepted.
  - Each saturates at 16'hFFFF.
  - Both clear to 0 on reset.
- **`MEM_STATS_EN` undefined:** the ports and counters are absent. All other behaviour is identical.

## Test plan
- **Reset state.** Hold reset for 2 cycles, then release. Expect ready=1, resp_valid=0, resp_data=0. A read of addr 6'h2A returns 0.
- **Write then read, default parameters.**
  - Stimulus: write addr 6'h15 with data 1 at edge T.
  - Expect ready low for T+1..T+2 and high at T+3.
  - Then read 6'h15 accepted at T+3.
  - Expect resp_valid only in cycle T+7 with resp_data=1; ready low T+4..T+7.
- **Valid held while busy.** Hold valid=1 with a changing address during RD_WAIT. Expect no extra acceptance and exactly one response strobe.
- **Reset mid-read.** Accept a read, then assert reset 2 cycles later. Expect no resp_valid at the original T+4 and ready=1 the cycle after reset deasserts.
- **Latency boundary.** With RD_LATENCY=1, WR_BUSY=0:
  - Four consecutive writes are accepted on 4 consecutive edges.
  - A read accepted at T responds in T+1, and ready is high again at T+2.
- **Statistics (`MEM_STATS_EN`).** Issue 3 reads and 5 writes. Expect rd_count=3 and wr_count=5. Force `wr_count` to 16'hFFFE and issue 3 writes; expect 16'hFFFF.

Source files
------------

// File: rtl/main_memory_responder_if.sv
// Request/response channel between the L2 memory port (master) and the main-memory
// responder (slave).
interface main_memory_responder_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 1
);
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/main_memory_responder.sv
// Main-memory model below L2: one outstanding request, fixed read latency, write busy window.
// Optional MEM_STATS_EN adds saturating rd_count/wr_count request counters.
module main_memory_responder #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 1,
    parameter int RD_LATENCY = 4,
    parameter int WR_BUSY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    main_memory_responder_if.slave  mem
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]             rd_count,
    output logic [15:0]             wr_count
`endif
);
    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [7:0] RD_LOAD = 8'(RD_LATENCY - 1);
    localparam logic [7:0] WR_LOAD = (WR_BUSY == 0) ? 8'd0 : 8'(WR_BUSY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RESP    = 2'd2,
        S_WR_BUSY = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [7:0]        cnt_reg;
    logic [DATA_W-1:0] data_q_reg;
    logic [DATA_W-1:0] mem_array [DEPTH];
    logic              accept;

    // Ready is purely a function of state, so acceptance needs only valid on top of it.
    assign accept = mem.mem_req_valid && (state_reg == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (!mem.mem_req_rw) begin
                        state_next = (RD_LOAD == 8'd0) ? S_RESP : S_RD_WAIT;
                    end else if (WR_BUSY != 0) begin
                        state_next = S_WR_BUSY;
                    end
                end
            end
            // The decrement that lands on zero is the last wait cycle; RESP follows it.
            S_RD_WAIT: if (cnt_reg <= 8'd1) state_next = S_RESP;
            S_RESP:    state_next = S_IDLE;
            S_WR_BUSY: if (cnt_reg == 8'd0) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req_ready  = (state_reg == S_IDLE);
        mem.mem_resp_valid = (state_reg == S_RESP);
        mem.mem_resp_data  = data_q_reg;
    end

    // Store, read snapshot and latency counter; reset clears every line.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= 8'd0;
            data_q_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_array[i] <= '0;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (mem.mem_req_rw) begin
                            mem_array[mem.mem_req_addr] <= mem.mem_req_data;
                            cnt_reg                     <= WR_LOAD;
                        end else begin
                            data_q_reg <= mem_array[mem.mem_req_addr];
                            cnt_reg    <= RD_LOAD;
                        end
                    end
                end
                S_RD_WAIT, S_WR_BUSY: begin
                    if (cnt_reg != 8'd0) cnt_reg <= cnt_reg - 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] rd_count_reg;
    logic [15:0] wr_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_reg <= 16'd0;
            wr_count_reg <= 16'd0;
        end else if (accept) begin
            if (!mem.mem_req_rw && rd_count_reg != 16'hFFFF) rd_count_reg <= rd_count_reg + 16'd1;
            if (mem.mem_req_rw && wr_count_reg != 16'hFFFF)  wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
`endif
endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench: default-parameter responder plus a RD_LATENCY=1/WR_BUSY=0 instance.
module tb_main_memory_responder;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    main_memory_responder_if #(.ADDR_W(6), .DATA_W(1)) bus_a ();
    main_memory_responder_if #(.ADDR_W(6), .DATA_W(1)) bus_b ();

`ifdef MEM_STATS_EN
    logic [15:0] rd_count_a, wr_count_a, rd_count_b, wr_count_b;
`endif

    main_memory_responder #(.ADDR_W(6), .DATA_W(1), .RD_LATENCY(4), .WR_BUSY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .mem   (bus_a.slave)
`ifdef MEM_STATS_EN
        ,
        .rd_count (rd_count_a),
        .wr_count (wr_count_a)
`endif
    );

    main_memory_responder #(.ADDR_W(6), .DATA_W(1), .RD_LATENCY(1), .WR_BUSY(0)) dut_fast (
        .clk   (clk),
        .reset (reset),
        .mem   (bus_b.slave)
`ifdef MEM_STATS_EN
        ,
        .rd_count (rd_count_b),
        .wr_count (wr_count_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after an edge with ready high; returns in cycle T+1.
    task automatic issue_a(input logic rw, input logic [5:0] addr, input logic d);
        bus_a.mem_req_valid = 1'b1;
        bus_a.mem_req_rw    = rw;
        bus_a.mem_req_addr  = addr;
        bus_a.mem_req_data  = d;
        @(posedge clk); #1;
        bus_a.mem_req_valid = 1'b0;
    endtask

    // Walks cycles T+1..T+ready_at checking strobe position, ready and read data.
    task automatic track_a(input int resp_at, input int ready_at, input logic exp_d, input string nm);
        for (int c = 1; c <= ready_at; c++) begin
            checks++;
            if (bus_a.mem_resp_valid !== (c == resp_at)) begin
                errors++;
                $display("FAIL %s resp_valid at T+%0d: got %b want %b", nm, c, bus_a.mem_resp_valid, (c == resp_at));
            end
            checks++;
            if (bus_a.mem_req_ready !== (c >= ready_at)) begin
                errors++;
                $display("FAIL %s ready at T+%0d: got %b want %b", nm, c, bus_a.mem_req_ready, (c >= ready_at));
            end
            if (c == resp_at) begin
                checks++;
                if (bus_a.mem_resp_data !== exp_d) begin
                    errors++;
                    $display("FAIL %s resp_data at T+%0d: got %b want %b", nm, c, bus_a.mem_resp_data, exp_d);
                end
            end
            if (c < ready_at) begin
                @(posedge clk); #1;
            end
        end
        $display("txn %s done", nm);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_a.mem_req_valid = 1'b0; bus_a.mem_req_rw = 1'b0; bus_a.mem_req_addr = '0; bus_a.mem_req_data = '0;
        bus_b.mem_req_valid = 1'b0; bus_b.mem_req_rw = 1'b0; bus_b.mem_req_addr = '0; bus_b.mem_req_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (bus_a.mem_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus_a.mem_req_ready); end
        checks++;
        if (bus_a.mem_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus_a.mem_resp_valid); end
        checks++;
        if (bus_a.mem_resp_data !== 1'b0) begin errors++; $display("FAIL reset_resp_data: got %b want 0", bus_a.mem_resp_data); end
        issue_a(1'b0, 6'h2A, 1'b0);
        track_a(4, 5, 1'b0, "reset_read_2A");
    endtask

    task automatic test_write_read();
        issue_a(1'b1, 6'h15, 1'b1);
        track_a(0, 3, 1'b0, "wr_15");
        issue_a(1'b0, 6'h15, 1'b0);
        track_a(4, 5, 1'b1, "rd_15");
        checks++;
        if (bus_a.mem_resp_data !== 1'b1) begin errors++; $display("FAIL hold_resp_data: got %b want 1", bus_a.mem_resp_data); end
        issue_a(1'b0, 6'h16, 1'b0);
        track_a(4, 5, 1'b0, "rd_16");
        issue_a(1'b1, 6'h15, 1'b0);
        track_a(0, 3, 1'b0, "wr_15_zero");
        issue_a(1'b0, 6'h15, 1'b0);
        track_a(4, 5, 1'b0, "rd_15_zero");
    endtask

    task automatic test_valid_held();
        int strobes;
        strobes = 0;
        issue_a(1'b1, 6'h3F, 1'b1);
        track_a(0, 3, 1'b0, "vh_wr_3F");
        bus_a.mem_req_valid = 1'b1;
        bus_a.mem_req_rw    = 1'b0;
        bus_a.mem_req_addr  = 6'h3F;
        @(posedge clk); #1;
        for (int c = 1; c <= 4; c++) begin
            bus_a.mem_req_addr = 6'(c);
            bus_a.mem_req_rw   = 1'b1;
            bus_a.mem_req_data = 1'b1;
            if (bus_a.mem_resp_valid === 1'b1) strobes++;
            checks++;
            if (bus_a.mem_req_ready !== 1'b0) begin errors++; $display("FAIL vh_ready at T+%0d: got %b want 0", c, bus_a.mem_req_ready); end
            if (c == 4) begin
                checks++;
                if (bus_a.mem_resp_data !== 1'b1) begin errors++; $display("FAIL vh_resp_data: got %b want 1", bus_a.mem_resp_data); end
            end
            @(posedge clk); #1;
        end
        bus_a.mem_req_valid = 1'b0;
        checks++;
        if (bus_a.mem_req_ready !== 1'b1) begin errors++; $display("FAIL vh_ready_back: got %b want 1", bus_a.mem_req_ready); end
        repeat (6) begin
            @(posedge clk); #1;
            if (bus_a.mem_resp_valid === 1'b1) strobes++;
        end
        checks++;
        if (strobes !== 1) begin errors++; $display("FAIL vh_strobes: got %0d want 1", strobes); end
        issue_a(1'b0, 6'h02, 1'b0);
        track_a(4, 5, 1'b0, "vh_rd_02");
    endtask

    task automatic test_reset_mid_read();
        issue_a(1'b0, 6'h3F, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_a.mem_req_valid = 1'b1;
        bus_a.mem_req_rw    = 1'b1;
        bus_a.mem_req_addr  = 6'h07;
        bus_a.mem_req_data  = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus_a.mem_req_valid = 1'b0;
        checks++;
        if (bus_a.mem_req_ready !== 1'b1) begin errors++; $display("FAIL rmr_ready: got %b want 1", bus_a.mem_req_ready); end
        checks++;
        if (bus_a.mem_resp_data !== 1'b0) begin errors++; $display("FAIL rmr_resp_data: got %b want 0", bus_a.mem_resp_data); end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus_a.mem_resp_valid !== 1'b0) begin errors++; $display("FAIL rmr_resp_valid step %0d: got %b want 0", c, bus_a.mem_resp_valid); end
            @(posedge clk); #1;
        end
        issue_a(1'b0, 6'h3F, 1'b0);
        track_a(4, 5, 1'b0, "rmr_rd_3F_cleared");
        issue_a(1'b0, 6'h07, 1'b0);
        track_a(4, 5, 1'b0, "rmr_rd_07");
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        pat = 4'b1101;
        bus_b.mem_req_valid = 1'b1;
        bus_b.mem_req_rw    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_b.mem_req_addr = 6'(i);
            bus_b.mem_req_data = pat[i];
            checks++;
            if (bus_b.mem_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready %0d: got %b want 1", i, bus_b.mem_req_ready); end
            @(posedge clk); #1;
            $display("txn b2b_wr addr %0d data %b", i, pat[i]);
        end
        bus_b.mem_req_valid = 1'b0;
        checks++;
        if (bus_b.mem_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_wr_ready: got %b want 1", bus_b.mem_req_ready); end
        for (int i = 0; i < 4; i++) begin
            bus_b.mem_req_valid = 1'b1;
            bus_b.mem_req_rw    = 1'b0;
            bus_b.mem_req_addr  = 6'(i);
            @(posedge clk); #1;
            bus_b.mem_req_valid = 1'b0;
            checks++;
            if (bus_b.mem_resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_valid %0d: got %b want 1", i, bus_b.mem_resp_valid); end
            checks++;
            if (bus_b.mem_resp_data !== pat[i]) begin errors++; $display("FAIL b2b_rd_data %0d: got %b want %b", i, bus_b.mem_resp_data, pat[i]); end
            checks++;
            if (bus_b.mem_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_rd_busy %0d: got %b want 0", i, bus_b.mem_req_ready); end
            @(posedge clk); #1;
            checks++;
            if (bus_b.mem_req_ready !== 1'b1 || bus_b.mem_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_rd_idle %0d: got ready=%b valid=%b want ready=1 valid=0", i, bus_b.mem_req_ready, bus_b.mem_resp_valid);
            end
            $display("txn b2b_rd addr %0d data %b", i, bus_b.mem_resp_data);
        end
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_a(1'b0, 6'(i), 1'b0);
            track_a(4, 5, 1'b0, "st_rd");
        end
        for (int i = 0; i < 5; i++) begin
            issue_a(1'b1, 6'(i), 1'b1);
            track_a(0, 3, 1'b0, "st_wr");
        end
        checks++;
        if (rd_count_a !== 16'd3) begin errors++; $display("FAIL stats_rd: got %0d want 3", rd_count_a); end
        checks++;
        if (wr_count_a !== 16'd5) begin errors++; $display("FAIL stats_wr: got %0d want 5", wr_count_a); end
        force dut.wr_count_reg = 16'hFFFE;
        @(negedge clk);
        release dut.wr_count_reg;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            issue_a(1'b1, 6'(i), 1'b0);
            track_a(0, 3, 1'b0, "st_sat_wr");
        end
        checks++;
        if (wr_count_a !== 16'hFFFF) begin errors++; $display("FAIL stats_wr_sat: got %h want ffff", wr_count_a); end
        checks++;
        if (rd_count_a !== 16'd3) begin errors++; $display("FAIL stats_rd_hold: got %0d want 3", rd_count_a); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_valid_held();
        test_reset_mid_read();
        test_back_to_back();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
